// File: rtl/if_id_queue.sv
// if_id_queue: IF->ID boundary buffer. A small FIFO of fetched (pc, inst) pairs.
// Fetch can run ahead while decode stalls. A flush drops wrong-path entries after a redirect.
//
// Ports
//   clk, rst                 clock (rising edge); synchronous active-high reset
//   flush                    empty the queue at the next edge (overrides enq/deq)
//   in_valid/in_ready        enqueue handshake; in_ready is purely registered
//   in_pc, in_inst           fetched entry
//   out_valid/out_ready      dequeue handshake toward decode
//   out_pc, out_inst         head entry; 0 / BUBBLE when empty
//   count                    current occupancy
//
// Optional build macro IF_ID_PRED_EN: adds the per-entry branch-prediction fields
//   in_pred_taken/in_pred_target and out_pred_taken/out_pred_target (0 when empty).
module if_id_queue #(
  parameter int unsigned       ADDR_W = 32,
  parameter int unsigned       INST_W = 32,
  parameter int unsigned       DEPTH  = 2,
  parameter logic [INST_W-1:0] BUBBLE = 32'h00000013
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ADDR_W-1:0]          in_pc,
  input  logic [INST_W-1:0]          in_inst,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ADDR_W-1:0]          out_pc,
  output logic [INST_W-1:0]          out_inst,
`ifdef IF_ID_PRED_EN
  input  logic                       in_pred_taken,
  input  logic [ADDR_W-1:0]          in_pred_target,
  output logic                       out_pred_taken,
  output logic [ADDR_W-1:0]          out_pred_target,
`endif
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [ADDR_W-1:0] pc_mem   [DEPTH];
  logic [INST_W-1:0] inst_mem [DEPTH];
`ifdef IF_ID_PRED_EN
  logic              taken_mem  [DEPTH];
  logic [ADDR_W-1:0] target_mem [DEPTH];
`endif

  logic push;
  logic pop;
  logic wr_en;

  assign in_ready  = (count_q != CNT_W'(DEPTH));
  assign out_valid = (count_q != '0);
  assign count     = count_q;

  assign push  = in_valid && in_ready;
  assign pop   = out_valid && out_ready;
  // A concurrent enqueue is dropped by flush.
  assign wr_en = push && !flush;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; empty-state outputs are forced below.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      pc_mem[wr_ptr_q]   <= in_pc;
      inst_mem[wr_ptr_q] <= in_inst;
`ifdef IF_ID_PRED_EN
      taken_mem[wr_ptr_q]  <= in_pred_taken;
      target_mem[wr_ptr_q] <= in_pred_target;
`endif
    end
  end

  always_comb begin
    out_pc   = '0;
    out_inst = BUBBLE;
`ifdef IF_ID_PRED_EN
    out_pred_taken  = 1'b0;
    out_pred_target = '0;
`endif
    if (out_valid) begin
      out_pc   = pc_mem[rd_ptr_q];
      out_inst = inst_mem[rd_ptr_q];
`ifdef IF_ID_PRED_EN
      out_pred_taken  = taken_mem[rd_ptr_q];
      out_pred_target = target_mem[rd_ptr_q];
`endif
    end
  end

endmodule

// File: doc/if_id_queue.md
Name: if_id_queue

Overview:
Parametrised IF→ID boundary buffer and successor to the single-register IF/ID latch. It holds up to DEPTH fetched (pc, inst) pairs in a small FIFO with valid/ready handshakes on both sides. The buffer lets fetch run ahead while decode stalls, and a flush discards wrong-path instructions after a branch or jump redirect. It sits between the fetch unit and the decoder.

Parameters:
ADDR_W, 32, width of PC fields
INST_W, 32, width of instruction fields
DEPTH, 2, number of entries; power of two, 2 to 16
BUBBLE, 32'h00000013, value driven on out_inst when empty (RV32I NOP, addi x0,x0,0)

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, synchronous, active-high
flush  input  1  discard all entries at next edge
in_valid  input  1  fetch presents an instruction
in_ready  output  1  queue can accept an entry this cycle
in_pc  input  ADDR_W  PC of fetched instruction
in_inst  input  INST_W  fetched instruction
out_valid  output  1  head entry valid for decode
out_ready  input  1  decode consumes head this cycle
out_pc  output  ADDR_W  PC of head entry
out_inst  output  INST_W  instruction of head entry
count  output  $clog2(DEPTH+1)  current occupancy

Behaviour:
- Reset: reset rst, synchronous, active-high; clock clk.
  - rst high at a clk edge sets read/write pointers to 0 and count to 0.
  - Consequent outputs: out_valid=0, in_ready=1, out_pc=0, out_inst=BUBBLE.
  - Storage contents are don't-care.
- Handshake and timing:
  - Enqueue when in_valid && in_ready. Dequeue when out_valid && out_ready.
  - in_ready = (count != DEPTH). It depends only on registered state; no combinational path from out_ready.
  - out_valid = (count != 0). out_pc/out_inst show the entry at the read pointer.
  - When empty: out_pc=0, out_inst=BUBBLE.
- Latency: an entry enqueued at edge N appears on the outputs after edge N (one cycle). There is no same-cycle bypass.
- Simultaneous enqueue and dequeue: both occur, count unchanged, pointers both advance.
- Full: in_ready=0. An enqueue is refused even if a dequeue happens in the same cycle; in_ready rises the cycle after the dequeue.
- Empty: a dequeue is ignored because out_valid=0, and count never underflows.
- Wrap-around:
  - Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
  - count is tracked separately and distinguishes full from empty.
- Flush:
  - Takes priority over enqueue and dequeue in the same cycle.
  - At the edge, pointers and count return to 0, and any concurrent enqueue is dropped.
  - Outputs show empty the following cycle.
- Priority order: rst > flush > enqueue/dequeue.
- FIFO order is strict; entries never reorder or duplicate.

Optional Feature:
IF_ID_PRED_EN
- When defined, the block adds these ports:
  - in_pred_taken (1) and in_pred_target (ADDR_W).
  - out_pred_taken and out_pred_target.
- These fields are stored per entry alongside pc/inst, with identical timing and flush behaviour.
- When empty, out_pred_taken=0 and out_pred_target=0.
- When undefined, these ports and their storage are absent, and all other behaviour is identical.

Test Plan:
- Reset then idle → out_valid=0, in_ready=1, count=0, out_inst=32'h00000013.
- Enqueue pc=0x100 inst=0x00500093 with out_ready=0 → next cycle out_valid=1, out_pc=0x100, count=1; enqueue 0x104 → count=2, in_ready=0.
- Full (DEPTH=2), in_valid=1 pc=0x108, out_ready=1 → 0x100 dequeued; 0x108 not accepted; count=1; in_ready=1 the next cycle.
- Streaming with in_valid=out_ready=1 for 20 cycles, PCs 0x0,0x4,... → outputs in order with one-cycle lag; count stays at 1; pointers wrap without loss.
- count=2 and flush=1 with in_valid=1 → next cycle count=0, out_valid=0; the concurrent entry is absent.
- rst asserted mid-stream with count=1 → next cycle count=0, out_valid=0, out_pc=0; with IF_ID_PRED_EN, out_pred_taken=0.
